layer_compositor: RTL and testbench

LAYER_COMPOSITOR -- requirements
Module: layer_compositor

---
 rtl/ppu_pkg.sv | 14 +
 rtl/priority_pick.sv | 25 ++
 rtl/layer_compositor.sv | 157 +++++++++++++++
 tb/tb_layer_compositor.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/ppu_pkg.sv
// Shared constants for the picture-processing unit.
// Register addresses and colour defaults.
package ppu_pkg;

  localparam logic [2:0] ADDR_MASK = 3'd0;
  localparam logic [2:0] ADDR_BG   = 3'd1;
  localparam logic [2:0] ADDR_KEY  = 3'd2;

  localparam int COLOR_W_DEF = 24;

  localparam logic [23:0] KEY_DEF = 24'h202020;
  localparam logic [23:0] BG_DEF  = 24'h202020;

endpackage

// File: rtl/priority_pick.sv
// Lowest-index-wins priority encoder.
// Returns the winning index and a found flag.
module priority_pick
  import ppu_pkg::*;
#(
  parameter int NUM_LAYERS = 20,
  localparam int IDX_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
  input  logic [NUM_LAYERS-1:0] req,
  output logic [IDX_W-1:0]      idx,
  output logic                  found
);

  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx   = IDX_W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/layer_compositor.sv
// Two-stage layer compositor with frame-synchronous
// double-buffered mask, background and key registers.
module layer_compositor
  import ppu_pkg::*;
#(
  parameter int NUM_LAYERS = 20,
  parameter int COLOR_W = COLOR_W_DEF,
  parameter logic [COLOR_W-1:0] KEY_RESET = COLOR_W'(KEY_DEF),
  parameter logic [COLOR_W-1:0] BG_RESET = COLOR_W'(BG_DEF),
  localparam int IDX_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          write,
  input  logic [2:0]                    address,
  input  logic [31:0]                   writedata,
  input  logic [9:0]                    hcount,
  input  logic [9:0]                    vcount,
  input  logic [NUM_LAYERS*COLOR_W-1:0] layer_rgb,
  output logic [COLOR_W-1:0]            RGB_output,
  output logic [IDX_W-1:0]              hit_layer,
  output logic                          hit_valid,
  output logic [9:0]                    hcount_out,
  output logic [9:0]                    vcount_out
);

  logic [NUM_LAYERS-1:0] mask_pend_q, mask_pend_d;
  logic [NUM_LAYERS-1:0] mask_act_q, mask_act_d;
  logic [COLOR_W-1:0]    bg_pend_q, bg_pend_d;
  logic [COLOR_W-1:0]    bg_act_q, bg_act_d;
  logic [COLOR_W-1:0]    key_pend_q, key_pend_d;
  logic [COLOR_W-1:0]    key_act_q, key_act_d;

  logic [NUM_LAYERS-1:0]         opaque_q, opaque_d;
  logic [NUM_LAYERS*COLOR_W-1:0] rgb1_q, rgb1_d;
  logic [COLOR_W-1:0]            bg1_q, bg1_d;
  logic [9:0]                    hc1_q, hc1_d;
  logic [9:0]                    vc1_q, vc1_d;

  logic [COLOR_W-1:0] rgb_out_q, rgb_out_d;
  logic [IDX_W-1:0]   hit_idx_q, hit_idx_d;
  logic               hit_vld_q, hit_vld_d;
  logic [9:0]         hc2_q, hc2_d;
  logic [9:0]         vc2_q, vc2_d;

  logic [IDX_W-1:0] pick_idx;
  logic             pick_found;
  logic             frame_start;
  logic             unused_ok;

  assign unused_ok = &{1'b0, writedata};
  assign frame_start = (hcount == 10'd0) && (vcount == 10'd0);

  priority_pick #(
    .NUM_LAYERS(NUM_LAYERS)
  ) u_pick (
    .req  (opaque_q),
    .idx  (pick_idx),
    .found(pick_found)
  );

  always_comb begin
    mask_pend_d = mask_pend_q;
    bg_pend_d   = bg_pend_q;
    key_pend_d  = key_pend_q;
    if (write) begin
      unique case (address)
        ADDR_MASK: mask_pend_d = writedata[NUM_LAYERS-1:0];
        ADDR_BG:   bg_pend_d   = writedata[COLOR_W-1:0];
        ADDR_KEY:  key_pend_d  = writedata[COLOR_W-1:0];
        default:   ;
      endcase
    end
  end

  // Active copies take the pre-write pending value at frame start.
  always_comb begin
    mask_act_d = mask_act_q;
    bg_act_d   = bg_act_q;
    key_act_d  = key_act_q;
    if (frame_start) begin
      mask_act_d = mask_pend_q;
      bg_act_d   = bg_pend_q;
      key_act_d  = key_pend_q;
    end
  end

  always_comb begin
    opaque_d = '0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      opaque_d[i] = mask_act_q[i] &&
        (layer_rgb[i*COLOR_W +: COLOR_W] != key_act_q);
    end
    rgb1_d = layer_rgb;
    bg1_d  = bg_act_q;
    hc1_d  = hcount;
    vc1_d  = vcount;
  end

  always_comb begin
    rgb_out_d = bg1_q;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      if (pick_found && (pick_idx == IDX_W'(i))) begin
        rgb_out_d = rgb1_q[i*COLOR_W +: COLOR_W];
      end
    end
    hit_idx_d = pick_found ? pick_idx : '0;
    hit_vld_d = pick_found;
    hc2_d     = hc1_q;
    vc2_d     = vc1_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mask_pend_q <= '1;
      mask_act_q  <= '1;
      bg_pend_q   <= BG_RESET;
      bg_act_q    <= BG_RESET;
      key_pend_q  <= KEY_RESET;
      key_act_q   <= KEY_RESET;
      opaque_q    <= '0;
      rgb1_q      <= '0;
      bg1_q       <= BG_RESET;
      hc1_q       <= '0;
      vc1_q       <= '0;
      rgb_out_q   <= BG_RESET;
      hit_idx_q   <= '0;
      hit_vld_q   <= 1'b0;
      hc2_q       <= '0;
      vc2_q       <= '0;
    end else begin
      mask_pend_q <= mask_pend_d;
      mask_act_q  <= mask_act_d;
      bg_pend_q   <= bg_pend_d;
      bg_act_q    <= bg_act_d;
      key_pend_q  <= key_pend_d;
      key_act_q   <= key_act_d;
      opaque_q    <= opaque_d;
      rgb1_q      <= rgb1_d;
      bg1_q       <= bg1_d;
      hc1_q       <= hc1_d;
      vc1_q       <= vc1_d;
      rgb_out_q   <= rgb_out_d;
      hit_idx_q   <= hit_idx_d;
      hit_vld_q   <= hit_vld_d;
      hc2_q       <= hc2_d;
      vc2_q       <= vc2_d;
    end
  end

  assign RGB_output = rgb_out_q;
  assign hit_layer  = hit_idx_q;
  assign hit_valid  = hit_vld_q;
  assign hcount_out = hc2_q;
  assign vcount_out = vc2_q;

endmodule

// File: tb/tb_layer_compositor.sv
// Directed bench for layer_compositor.
// Expected values are hand-computed per step.
module tb_layer_compositor;

  localparam int NL = 20;
  localparam int CW = 24;

  logic          clk = 1'b0;
  logic          reset;
  logic          write;
  logic [2:0]    address;
  logic [31:0]   writedata;
  logic [9:0]    hcount;
  logic [9:0]    vcount;
  logic [NL*CW-1:0] layer_rgb;
  logic [CW-1:0] rgb_out;
  logic [4:0]    hit_layer;
  logic          hit_valid;
  logic [9:0]    hcount_out;
  logic [9:0]    vcount_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  layer_compositor dut (
    .clk       (clk),
    .reset     (reset),
    .write     (write),
    .address   (address),
    .writedata (writedata),
    .hcount    (hcount),
    .vcount    (vcount),
    .layer_rgb (layer_rgb),
    .RGB_output(rgb_out),
    .hit_layer (hit_layer),
    .hit_valid (hit_valid),
    .hcount_out(hcount_out),
    .vcount_out(vcount_out)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_all(input logic [CW-1:0] c);
    for (int i = 0; i < NL; i++) layer_rgb[i*CW +: CW] = c;
  endtask

  task automatic set_layer(input int i, input logic [CW-1:0] c);
    layer_rgb[i*CW +: CW] = c;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    write     = 1'b1;
    address   = a;
    writedata = d;
    tick();
    write     = 1'b0;
  endtask

  task automatic chk_px(input string tag,
                        input logic [CW-1:0] rgb,
                        input logic [4:0] hl,
                        input logic hv);
    chk({tag, "_rgb"}, 32'(rgb_out), 32'(rgb));
    chk({tag, "_hl"}, 32'(hit_layer), 32'(hl));
    chk({tag, "_hv"}, 32'(hit_valid), 32'(hv));
  endtask

  initial begin
    reset     = 1'b1;
    write     = 1'b0;
    address   = '0;
    writedata = '0;
    hcount    = 10'd5;
    vcount    = 10'd5;
    set_all(24'h202020);
    tick();
    tick();
    chk_px("rst", 24'h202020, 5'd0, 1'b0);
    chk("rst_hc", 32'(hcount_out), 32'd0);
    chk("rst_vc", 32'(vcount_out), 32'd0);

    reset = 1'b0;
    tick();
    tick();
    chk_px("allkey", 24'h202020, 5'd0, 1'b0);
    chk("allkey_hc", 32'(hcount_out), 32'd5);
    chk("allkey_vc", 32'(vcount_out), 32'd5);

    set_layer(3, 24'hFF0000);
    set_layer(7, 24'h00FF00);
    tick();
    tick();
    chk_px("l3win", 24'hFF0000, 5'd3, 1'b1);

    hcount = 10'd6;
    wr(3'd0, 32'h000F_FFF7);
    tick();
    tick();
    chk_px("mask_pend", 24'hFF0000, 5'd3, 1'b1);

    hcount = 10'd0;
    vcount = 10'd0;
    tick();
    hcount = 10'd1;
    tick();
    tick();
    chk_px("mask_act", 24'h00FF00, 5'd7, 1'b1);
    chk("mask_act_hc", 32'(hcount_out), 32'd1);
    chk("mask_act_vc", 32'(vcount_out), 32'd0);

    set_all(24'h202020);
    hcount = 10'd0;
    vcount = 10'd0;
    wr(3'd1, 32'h0000_00FF);
    hcount = 10'd1;
    tick();
    tick();
    chk_px("bg_same_frame", 24'h202020, 5'd0, 1'b0);

    hcount = 10'd0;
    tick();
    hcount = 10'd1;
    tick();
    tick();
    chk_px("bg_next_frame", 24'h0000FF, 5'd0, 1'b0);

    set_layer(3, 24'hFF0000);
    set_layer(7, 24'h00FF00);
    hcount = 10'd7;
    vcount = 10'd3;
    wr(3'd0, 32'h000F_FFFF);
    wr(3'd2, 32'h00FF_0000);
    wr(3'd5, 32'h0000_0000);
    tick();
    tick();
    chk_px("key_pend", 24'h00FF00, 5'd7, 1'b1);

    set_all(24'hFF0000);
    set_layer(7, 24'h00FF00);
    hcount = 10'd0;
    vcount = 10'd0;
    tick();
    hcount = 10'd1;
    tick();
    tick();
    chk_px("key_act", 24'h00FF00, 5'd7, 1'b1);

    set_layer(7, 24'hFF0000);
    tick();
    tick();
    chk_px("addr5_ign", 24'h0000FF, 5'd0, 1'b0);

    set_all(24'h202020);
    set_layer(3, 24'hFF0000);
    vcount = 10'd9;
    hcount = 10'd10;
    tick();
    hcount = 10'd11;
    tick();
    hcount = 10'd12;
    reset  = 1'b1;
    tick();
    chk_px("mid_rst", 24'h202020, 5'd0, 1'b0);
    chk("mid_rst_hc", 32'(hcount_out), 32'd0);
    reset  = 1'b0;
    hcount = 10'd13;
    tick();
    chk("mid_rst1_hv", 32'(hit_valid), 32'd0);
    chk("mid_rst1_hc", 32'(hcount_out), 32'd0);
    hcount = 10'd14;
    tick();
    chk_px("mid_rst2", 24'hFF0000, 5'd3, 1'b1);
    chk("mid_rst2_hc", 32'(hcount_out), 32'd13);
    chk("mid_rst2_vc", 32'(vcount_out), 32'd9);
    hcount = 10'd15;
    tick();
    chk("mid_rst3_hc", 32'(hcount_out), 32'd14);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
